// File: rtl/memoria_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// memoria_pkg - shared widths, FSM states and request record for the
// cache-to-memory interface.  Revision: 1.0
// ----------------------------------------------------------------------------
package memoria_pkg;

  localparam int DATA_W = 3;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic              wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              fill;
    logic [ADDR_W-1:0] fill_addr;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/contador_espera.sv
`default_nettype none
// ----------------------------------------------------------------------------
// contador_espera - memory-access wait counter shared by the WB and FILL phases.
// Revision: 1.0
// ----------------------------------------------------------------------------
module contador_espera #(
  parameter int LATENCY = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [CNT_W-1:0] count_d, count_q;

  // Saturates on the last wait cycle; the FSM reloads it on every state change.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !done) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CNT_W'(LATENCY - 1));

endmodule
`default_nettype wire

// File: rtl/controlador_memoria.sv
`default_nettype none
// ----------------------------------------------------------------------------
// controlador_memoria - main-memory responder: optional writeback, optional
// fill, fixed access latency, valid/ready response.  Revision: 1.0
// ----------------------------------------------------------------------------
module controlador_memoria
  import memoria_pkg::*;
#(
  parameter int DEPTH   = 2 ** ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [DATA_W-1:0] req_wb_data,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy
);

  state_t            state_d, state_q;
  req_t              req_d, req_q;
  logic [DATA_W-1:0] resp_data_d, resp_data_q;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic cnt_load;
  logic cnt_en;
  logic cnt_done;

  contador_espera #(
    .LATENCY (LATENCY)
  ) u_contador_espera (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (cnt_load),
    .en      (cnt_en),
    .done    (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    resp_data_d = resp_data_q;
    mem_d       = mem_q;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = '{wb:        req_wb,
                    wb_addr:   req_wb_addr,
                    wb_data:   req_wb_data,
                    fill:      req_fill,
                    fill_addr: req_fill_addr};
          // A request without a fill answers with zero, never stale data.
          resp_data_d = '0;
          if (req_wb) begin
            state_d = ST_WB;
          end else if (req_fill) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_RESP;
          end
        end
      end

      ST_WB: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          mem_d[req_q.wb_addr] = req_q.wb_data;
          state_d = req_q.fill ? ST_FILL : ST_RESP;
        end
      end

      ST_FILL: begin
        cnt_en = 1'b1;
        // The writeback committed on an earlier edge, so a same-address fill
        // already sees the evicted word here.
        if (cnt_done) begin
          resp_data_d = mem_q[req_q.fill_addr];
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every state change starts a fresh wait window.
  assign cnt_load = (state_d != state_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      resp_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      resp_data_q <= resp_data_d;
      mem_q       <= mem_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign resp_data  = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_memoria.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_controlador_memoria - self-checking bench against a word-array model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_controlador_memoria;

  localparam int LAT = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_wb = 1'b0;
  logic [3:0] req_wb_addr = '0;
  logic [2:0] req_wb_data = '0;
  logic       req_fill = 1'b0;
  logic [3:0] req_fill_addr = '0;
  logic       resp_ready = 1'b0;
  logic       req_ready;
  logic       resp_valid;
  logic [2:0] resp_data;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [2:0] model_mem [16];

  always #5 clock = ~clock;

  controlador_memoria #(
    .DEPTH   (16),
    .LATENCY (LAT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wb        (req_wb),
    .req_wb_addr   (req_wb_addr),
    .req_wb_data   (req_wb_data),
    .req_fill      (req_fill),
    .req_fill_addr (req_fill_addr),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .busy          (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(input logic wb, input logic fl);
    return (wb ? LAT : 0) + (fl ? LAT : 0) + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 3'(i);
  endtask

  // Returns what a transaction looked like from the cache side; updates the model.
  task automatic run_txn(input logic wb, input logic [3:0] wa, input logic [2:0] wd,
                         input logic fl, input logic [3:0] fa, input int bp,
                         output int lat, output logic [2:0] data, output logic [2:0] expd,
                         output logic early_ok, output logic bp_ok, output logic after_ok);
    if (wb) model_mem[wa] = wd;
    expd = fl ? model_mem[fa] : 3'b000;
    bp_ok = 1'b1;
    after_ok = 1'b0;
    data = 3'bxxx;
    @(negedge clock);
    req_valid = 1'b1; req_wb = wb; req_wb_addr = wa; req_wb_data = wd;
    req_fill = fl; req_fill_addr = fa; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_wb = 1'($urandom); req_wb_addr = 4'($urandom); req_wb_data = 3'($urandom);
    req_fill = 1'($urandom); req_fill_addr = 4'($urandom);
    @(negedge clock);
    lat = 1;
    early_ok = (req_ready === 1'b0) && (busy === 1'b1);
    while (resp_valid !== 1'b1 && lat < 64) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) early_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    if (resp_valid !== 1'b1) return;
    data = resp_data;
    for (int k = 0; k < bp; k++) begin
      req_valid = 1'b1;
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_data !== data || req_ready !== 1'b0 || busy !== 1'b1)
        bp_ok = 1'b0;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    after_ok = (req_ready === 1'b1) && (resp_valid === 1'b0) && (busy === 1'b0);
  endtask

  int lat;
  logic [2:0] data, expd;
  logic early_ok, bp_ok, after_ok;

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (resp_data !== 3'b000) $display("FAIL reset_resp_data: got %b expected 000", resp_data); else n_pass++;
  endtask

  task automatic test_store_reset();
    for (int a = 0; a < 16; a++) begin
      run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'(a), 0, lat, data, expd, early_ok, bp_ok, after_ok);
      n_total++; if (data !== 3'(a)) $display("FAIL store_reset[%0d]: got %b expected %b", a, data, 3'(a)); else n_pass++;
    end
  endtask

  task automatic test_fill_only();
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd5, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (lat != exp_lat(1'b0, 1'b1)) $display("FAIL fill_only_latency: got %0d expected %0d", lat, exp_lat(1'b0, 1'b1)); else n_pass++;
    n_total++; if (data !== 3'b101) $display("FAIL fill_only_data: got %b expected 101", data); else n_pass++;
    n_total++; if (early_ok !== 1'b1) $display("FAIL fill_only_busy: got %b expected 1", early_ok); else n_pass++;
    n_total++; if (after_ok !== 1'b1) $display("FAIL fill_only_release: got %b expected 1", after_ok); else n_pass++;
  endtask

  task automatic test_wb_fill_same();
    run_txn(1'b1, 4'd9, 3'b010, 1'b1, 4'd9, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (lat != exp_lat(1'b1, 1'b1)) $display("FAIL wb_fill_same_latency: got %0d expected %0d", lat, exp_lat(1'b1, 1'b1)); else n_pass++;
    n_total++; if (data !== 3'b010) $display("FAIL wb_fill_same_data: got %b expected 010", data); else n_pass++;
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd9, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== 3'b010) $display("FAIL wb_same_readback: got %b expected 010", data); else n_pass++;
  endtask

  task automatic test_wb_fill_diff();
    run_txn(1'b1, 4'd2, 3'b111, 1'b1, 4'd6, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== 3'b110) $display("FAIL wb_fill_diff_data: got %b expected 110", data); else n_pass++;
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd2, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== 3'b111) $display("FAIL wb_diff_readback: got %b expected 111", data); else n_pass++;
  endtask

  task automatic test_wb_only();
    run_txn(1'b1, 4'd12, 3'b001, 1'b0, 4'd12, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (lat != exp_lat(1'b1, 1'b0)) $display("FAIL wb_only_latency: got %0d expected %0d", lat, exp_lat(1'b1, 1'b0)); else n_pass++;
    n_total++; if (data !== 3'b000) $display("FAIL wb_only_data: got %b expected 000", data); else n_pass++;
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd13, 4, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== expd) $display("FAIL backpressure_data: got %b expected %b", data, expd); else n_pass++;
    n_total++; if (bp_ok !== 1'b1) $display("FAIL backpressure_hold: got %b expected 1", bp_ok); else n_pass++;
    n_total++; if (after_ok !== 1'b1) $display("FAIL backpressure_release: got %b expected 1", after_ok); else n_pass++;
  endtask

  task automatic test_reset_mid_wb();
    @(negedge clock);
    req_valid = 1'b1; req_wb = 1'b1; req_wb_addr = 4'd3; req_wb_data = 3'b000; req_fill = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    n_total++; if (busy !== 1'b1) $display("FAIL mid_wb_busy: got %b expected 1", busy); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL mid_wb_req_ready: got %b expected 1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_wb_reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL mid_wb_resp_valid: got %b expected 0", resp_valid); else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd3, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== 3'b011) $display("FAIL mid_wb_readback: got %b expected 011", data); else n_pass++;
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd9, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== 3'b001) $display("FAIL mid_wb_store_reload: got %b expected 001", data); else n_pass++;
  endtask

  task automatic test_neither();
    run_txn(1'b0, 4'd7, 3'b000, 1'b0, 4'd7, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (lat != 1) $display("FAIL neither_latency: got %0d expected 1", lat); else n_pass++;
    n_total++; if (data !== 3'b000) $display("FAIL neither_data: got %b expected 000", data); else n_pass++;
    run_txn(1'b0, 4'd0, 3'd0, 1'b1, 4'd7, 0, lat, data, expd, early_ok, bp_ok, after_ok);
    n_total++; if (data !== 3'b111) $display("FAIL neither_store: got %b expected 111", data); else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic wb, fl;
      logic [3:0] wa, fa;
      logic [2:0] wd;
      int bp;
      wb = 1'($urandom); fl = 1'($urandom);
      wa = 4'($urandom); fa = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      wd = 3'($urandom); bp = $urandom_range(0, 2);
      run_txn(wb, wa, wd, fl, fa, bp, lat, data, expd, early_ok, bp_ok, after_ok);
      n_total++; if (lat != exp_lat(wb, fl)) $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, exp_lat(wb, fl)); else n_pass++;
      n_total++; if (data !== expd) $display("FAIL rand_data[%0d]: got %b expected %b", t, data, expd); else n_pass++;
      n_total++; if (early_ok !== 1'b1 || after_ok !== 1'b1 || bp_ok !== 1'b1)
        $display("FAIL rand_handshake[%0d]: got busy=%b release=%b hold=%b expected 1 1 1", t, early_ok, after_ok, bp_ok);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_store_reset();
    test_fill_only();
    test_wb_fill_same();
    test_wb_fill_diff();
    test_wb_only();
    test_backpressure();
    test_reset_mid_wb();
    test_neither();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
